// File: rtl/rps_match_engine_pkg.sv
// Shared types and pure helpers for the stone/paper/scissors match engine.
// Judging and the computer-move mapping live here so both are combinational and reusable.
package rps_pkg;

    typedef enum logic [1:0] {
        STONE    = 2'b00,
        PAPER    = 2'b01,
        SCISSORS = 2'b10,
        INVALID  = 2'b11
    } move_t;

    typedef enum logic [1:0] {
        TIE = 2'b00,
        P1  = 2'b01,
        P2  = 2'b10,
        INV = 2'b11
    } result_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_JUDGE = 3'b001,
        S_SCORE = 3'b010,
        S_DONE  = 3'b011
    } state_t;

    function automatic result_t judge(input move_t a, input move_t b);
        result_t r;
        r = P2;
        if (a == INVALID || b == INVALID) begin
            r = INV;
        end else if (a == b) begin
            r = TIE;
        end else begin
            case (a)
                STONE:    r = (b == SCISSORS) ? P1 : P2;
                PAPER:    r = (b == STONE)    ? P1 : P2;
                default:  r = (b == PAPER)    ? P1 : P2;
            endcase
        end
        return r;
    endfunction

    // The computer never plays INVALID: fall back to the next bit pair, then to STONE.
    function automatic move_t computer_move(input logic [7:0] s);
        move_t m;
        if (s[1:0] != 2'b11) begin
            m = move_t'(s[1:0]);
        end else if (s[3:2] != 2'b11) begin
            m = move_t'(s[3:2]);
        end else begin
            m = STONE;
        end
        return m;
    endfunction

endpackage

// File: rtl/rps_match_engine_if.sv
// Player-side signal bundle for the match engine: move/control inputs and score/status outputs.
interface rps_match_engine_if #(
    parameter int MAX_ROUNDS = 7
);
    localparam int CNT_W = $clog2(MAX_ROUNDS + 1);

    logic [1:0]       p1_move;
    logic [1:0]       p2_move;
    logic             start;
    logic             mode;
    logic             clear_match;
    logic [1:0]       round_winner;
    logic             round_valid;
    logic [CNT_W-1:0] p1_score;
    logic [CNT_W-1:0] p2_score;
    logic [CNT_W-1:0] round_count;
    logic [CNT_W-1:0] tie_count;
    logic             match_over;
    logic [1:0]       match_winner;
    logic [2:0]       state;
    logic [2:0]       debug;

    modport master (
        output p1_move, p2_move, start, mode, clear_match,
        input  round_winner, round_valid, p1_score, p2_score, round_count,
               tie_count, match_over, match_winner, state, debug
    );

    modport slave (
        input  p1_move, p2_move, start, mode, clear_match,
        output round_winner, round_valid, p1_score, p2_score, round_count,
               tie_count, match_over, match_winner, state, debug
    );
endinterface

// File: rtl/rps_match_engine_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) feeding the computer player.
module rps_lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] o_state
);
    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign o_state = r_lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end
endmodule

// File: rtl/rps_match_engine.sv
// Best-of-N stone/paper/scissors controller: capture -> judge -> score, with a DONE hold state.
// Player 2 is either an external input or the internal LFSR, chosen at the first round of a match.
module rps_match_engine
    import rps_pkg::*;
#(
    parameter int         ROUNDS_TO_WIN = 2,
    parameter int         MAX_ROUNDS    = 7,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input logic               clk,
    input logic               reset,
    rps_match_engine_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_ROUNDS + 1);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
    localparam logic [CNT_W-1:0] RTW_C = CNT_W'(ROUNDS_TO_WIN);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_ROUNDS);

    state_t           r_state;
    move_t            r_p1_move;
    move_t            r_p2_move;
    logic             r_mode_latched;
    result_t          r_round_winner;
    logic             r_round_valid;
    logic [CNT_W-1:0] r_p1_score;
    logic [CNT_W-1:0] r_p2_score;
    logic [CNT_W-1:0] r_round_count;
    logic [CNT_W-1:0] r_tie_count;
    logic             r_match_over;
    result_t          r_match_winner;

    logic [7:0]       w_lfsr;
    logic             w_mode_eff;
    logic [CNT_W-1:0] w_p1_nxt;
    logic [CNT_W-1:0] w_p2_nxt;
    logic [CNT_W-1:0] w_rc_nxt;
    logic [CNT_W-1:0] w_tc_nxt;
    logic             w_end;
    result_t          w_winner;

    rps_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .o_state (w_lfsr)
    );

    // Mode is only sampled while no valid round has been played in this match.
    assign w_mode_eff = (r_round_count == '0) ? bus.mode : r_mode_latched;

    always_comb begin
        w_p1_nxt = r_p1_score;
        w_p2_nxt = r_p2_score;
        w_rc_nxt = r_round_count;
        w_tc_nxt = r_tie_count;
        case (r_round_winner)
            P1: begin
                w_p1_nxt = r_p1_score + ONE_C;
                w_rc_nxt = r_round_count + ONE_C;
            end
            P2: begin
                w_p2_nxt = r_p2_score + ONE_C;
                w_rc_nxt = r_round_count + ONE_C;
            end
            TIE: begin
                w_tc_nxt = r_tie_count + ONE_C;
                w_rc_nxt = r_round_count + ONE_C;
            end
            default: ;
        endcase

        w_end    = 1'b0;
        w_winner = TIE;
        if (w_p1_nxt == RTW_C) begin
            w_end    = 1'b1;
            w_winner = P1;
        end else if (w_p2_nxt == RTW_C) begin
            w_end    = 1'b1;
            w_winner = P2;
        end else if (w_rc_nxt == MAX_C) begin
            w_end = 1'b1;
            if (w_p1_nxt > w_p2_nxt) begin
                w_winner = P1;
            end else if (w_p2_nxt > w_p1_nxt) begin
                w_winner = P2;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_p1_move      <= STONE;
            r_p2_move      <= STONE;
            r_mode_latched <= 1'b0;
            r_round_winner <= TIE;
            r_round_valid  <= 1'b0;
            r_p1_score     <= '0;
            r_p2_score     <= '0;
            r_round_count  <= '0;
            r_tie_count    <= '0;
            r_match_over   <= 1'b0;
            r_match_winner <= TIE;
        end else begin
            r_round_valid <= 1'b0;
            if (bus.clear_match) begin
                r_state        <= S_IDLE;
                r_mode_latched <= 1'b0;
                r_round_winner <= TIE;
                r_p1_score     <= '0;
                r_p2_score     <= '0;
                r_round_count  <= '0;
                r_tie_count    <= '0;
                r_match_over   <= 1'b0;
                r_match_winner <= TIE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_p1_move <= move_t'(bus.p1_move);
                            r_p2_move <= w_mode_eff ? computer_move(w_lfsr) : move_t'(bus.p2_move);
                            if (r_round_count == '0) begin
                                r_mode_latched <= bus.mode;
                            end
                            r_state <= S_JUDGE;
                        end
                    end
                    S_JUDGE: begin
                        r_round_winner <= judge(r_p1_move, r_p2_move);
                        r_state        <= S_SCORE;
                    end
                    S_SCORE: begin
                        r_p1_score    <= w_p1_nxt;
                        r_p2_score    <= w_p2_nxt;
                        r_round_count <= w_rc_nxt;
                        r_tie_count   <= w_tc_nxt;
                        r_round_valid <= 1'b1;
                        if (w_end) begin
                            r_match_over   <= 1'b1;
                            r_match_winner <= w_winner;
                            r_state        <= S_DONE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_DONE:  r_state <= S_DONE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.round_winner = r_round_winner;
    assign bus.round_valid  = r_round_valid;
    assign bus.p1_score     = r_p1_score;
    assign bus.p2_score     = r_p2_score;
    assign bus.round_count  = r_round_count;
    assign bus.tie_count    = r_tie_count;
    assign bus.match_over   = r_match_over;
    assign bus.match_winner = r_match_winner;
    assign bus.state        = r_state;
    assign bus.debug        = {r_mode_latched, r_p2_move};
endmodule

// File: tb/tb_rps_match_engine.sv
// Scoreboard bench for rps_match_engine: directed scenarios plus random matches against a
// modular-arithmetic reference model; a monitor checks every round_valid pulse.
module tb_rps_match_engine;
    localparam int RTW   = 2;
    localparam int MAXR  = 7;
    localparam logic [7:0] SEED = 8'hA5;

    typedef struct {
        logic [1:0] rw;
        int         p1;
        int         p2;
        int         rc;
        int         tc;
        logic       over;
        logic [1:0] mw;
        logic [2:0] dbg;
    } exp_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    exp_t q[$];

    // Reference model state
    logic [7:0] m_lfsr;
    int         m_p1, m_p2, m_rc, m_tc;
    logic       m_over;
    logic [1:0] m_mw;
    logic       m_mode;
    logic [1:0] m_p2cap;

    rps_match_engine_if #(.MAX_ROUNDS(MAXR)) bus ();

    rps_match_engine #(
        .ROUNDS_TO_WIN (RTW),
        .MAX_ROUNDS    (MAXR),
        .LFSR_SEED     (SEED)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [1:0] comp(input logic [7:0] s);
        if (s[1:0] != 2'b11) return s[1:0];
        if (s[3:2] != 2'b11) return s[3:2];
        return 2'b00;
    endfunction

    task automatic model_zero();
        m_p1 = 0; m_p2 = 0; m_rc = 0; m_tc = 0;
        m_over = 1'b0; m_mw = 2'b00; m_mode = 1'b0;
    endtask

    // Monitor: every round_valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!reset && bus.round_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_round_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_round_winner", bus.round_winner, e.rw);
                chk("sb_p1_score", bus.p1_score, e.p1);
                chk("sb_p2_score", bus.p2_score, e.p2);
                chk("sb_round_count", bus.round_count, e.rc);
                chk("sb_tie_count", bus.tie_count, e.tc);
                chk("sb_match_over", bus.match_over, e.over);
                chk("sb_match_winner", bus.match_winner, e.mw);
                chk("sb_debug", bus.debug, e.dbg);
            end
        end
    end

    task automatic play_round(input logic [1:0] a, input logic [1:0] b, input logic md,
                              input bit poke_score);
        exp_t       e;
        logic [1:0] p2eff;
        int         d;
        @(negedge clk);
        if (m_rc == 0) m_mode = md;
        p2eff = m_mode ? comp(m_lfsr) : b;
        m_p2cap = p2eff;
        if (a == 2'b11 || p2eff == 2'b11) begin
            e.rw = 2'b11;
        end else begin
            // Stone=0, paper=1, scissors=2: the mover one step ahead mod 3 wins.
            d = (int'(a) - int'(p2eff) + 3) % 3;
            e.rw = (d == 0) ? 2'b00 : (d == 1) ? 2'b01 : 2'b10;
            m_rc++;
            if (d == 0) m_tc++;
            else if (d == 1) m_p1++;
            else m_p2++;
            if (m_p1 == RTW) begin
                m_over = 1'b1; m_mw = 2'b01;
            end else if (m_p2 == RTW) begin
                m_over = 1'b1; m_mw = 2'b10;
            end else if (m_rc == MAXR) begin
                m_over = 1'b1;
                m_mw = (m_p1 > m_p2) ? 2'b01 : (m_p2 > m_p1) ? 2'b10 : 2'b00;
            end
        end
        e.p1 = m_p1; e.p2 = m_p2; e.rc = m_rc; e.tc = m_tc;
        e.over = m_over; e.mw = m_mw; e.dbg = {m_mode, p2eff};
        q.push_back(e);
        bus.start = 1'b1; bus.p1_move = a; bus.p2_move = b; bus.mode = md;
        @(negedge clk);
        bus.start = 1'b0;
        chk("state_judge", bus.state, 1);
        @(negedge clk);
        chk("rw_at_n1", bus.round_winner, e.rw);
        chk("state_score", bus.state, 2);
        if (poke_score) bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("state_after_score", bus.state, m_over ? 3 : 0);
    endtask

    task automatic clear_match();
        @(negedge clk);
        bus.clear_match = 1'b1;
        @(negedge clk);
        bus.clear_match = 1'b0;
        model_zero();
        chk("clr_state", bus.state, 0);
        chk("clr_p1", bus.p1_score, 0);
        chk("clr_p2", bus.p2_score, 0);
        chk("clr_rc", bus.round_count, 0);
        chk("clr_tc", bus.tie_count, 0);
        chk("clr_over", bus.match_over, 0);
        chk("clr_rw", bus.round_winner, 0);
        chk("clr_mw", bus.match_winner, 0);
        chk("clr_mode", bus.debug[2], 0);
    endtask

    task automatic check_done(input int mw);
        chk("done_state", bus.state, 3);
        chk("done_over", bus.match_over, 1);
        chk("done_winner", bus.match_winner, mw);
    endtask

    initial begin
        errors = 0; checks = 0;
        model_zero();
        m_p2cap = 2'b00;
        bus.p1_move = 2'b00; bus.p2_move = 2'b00; bus.start = 1'b0;
        bus.mode = 1'b0; bus.clear_match = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_state", bus.state, 0);
        chk("rst_rw", bus.round_winner, 0);
        chk("rst_rv", bus.round_valid, 0);
        chk("rst_scores", bus.p1_score + bus.p2_score, 0);
        chk("rst_counts", bus.round_count + bus.tie_count, 0);
        chk("rst_over", bus.match_over, 0);
        chk("rst_debug", bus.debug, 0);

        // Two straight P1 wins end the match.
        play_round(2'b00, 2'b10, 1'b0, 1'b0);
        play_round(2'b01, 2'b00, 1'b0, 1'b0);
        check_done(1);
        clear_match();

        // Invalid round changes nothing; a tie counts as a round.
        play_round(2'b11, 2'b00, 1'b0, 1'b0);
        chk("inv_rc", bus.round_count, 0);
        play_round(2'b10, 2'b10, 1'b0, 1'b0);
        chk("tie_tc", bus.tie_count, 1);
        clear_match();

        // Draw by round limit, then a start in DONE is ignored.
        for (int i = 0; i < MAXR; i++) play_round(2'b01, 2'b01, 1'b0, 1'b0);
        check_done(0);
        chk("draw_rc", bus.round_count, MAXR);
        @(negedge clk);
        bus.start = 1'b1; bus.p1_move = 2'b00; bus.p2_move = 2'b10;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check_done(0);
        chk("done_rc_hold", bus.round_count, MAXR);
        clear_match();

        // Computer mode; mode input drops to 0 once the match is under way.
        for (int i = 0; i < 5; i++) begin
            if (m_over) clear_match();
            play_round(2'b00, 2'b00, (m_rc == 0) ? 1'b1 : 1'b0, 1'b0);
            chk("comp_not_inv", (bus.debug[1:0] == 2'b11) ? 1 : 0, 0);
            chk("comp_mode_latched", bus.debug[2], 1);
        end
        clear_match();

        // Start during SCORE is not queued.
        play_round(2'b00, 2'b01, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("score_poke_state", bus.state, 0);
        chk("score_poke_rc", bus.round_count, m_rc);

        // clear_match beats start in IDLE: no capture, stays IDLE.
        @(negedge clk);
        bus.start = 1'b1; bus.clear_match = 1'b1; bus.mode = 1'b0;
        bus.p1_move = 2'b01; bus.p2_move = m_p2cap ^ 2'b01;
        @(negedge clk);
        bus.start = 1'b0; bus.clear_match = 1'b0;
        model_zero();
        chk("clrstart_state", bus.state, 0);
        chk("clrstart_debug", bus.debug, {1'b0, m_p2cap});
        repeat (3) @(negedge clk);
        chk("clrstart_idle", bus.state, 0);

        // Reset in JUDGE clears immediately with no pulse.
        play_round(2'b00, 2'b10, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.p1_move = 2'b01; bus.p2_move = 2'b00;
        @(negedge clk);
        bus.start = 1'b0;
        chk("pre_rst_judge", bus.state, 1);
        reset = 1'b1;
        #1;
        chk("midrst_state", bus.state, 0);
        chk("midrst_rw", bus.round_winner, 0);
        chk("midrst_rv", bus.round_valid, 0);
        chk("midrst_p1", bus.p1_score, 0);
        chk("midrst_rc", bus.round_count, 0);
        chk("midrst_debug", bus.debug, 0);
        model_zero();
        m_p2cap = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("postrst_state", bus.state, 0);

        // Random matches.
        for (int k = 0; k < 80; k++) begin
            if (m_over) begin
                check_done(m_mw);
                clear_match();
            end
            play_round(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), (k % 7) == 3);
        end

        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
